// File: rtl/idma_stream_sched.sv
// Purpose: round-robin job scheduler from NumStreams iDMA front-ends onto one back-end, with per-stream IDs and in-order completion tracking.
// Latency: a job accepted at edge N drives req_valid_o from N+1; counter updates are visible one cycle after the causing edge.
// Backpressure: valid/ready; accept needs a free output register (or one draining this cycle) and a free tracking slot (registered count, no bypass).
module idma_stream_sched #(
  parameter int unsigned NumStreams     = 4,
  parameter int unsigned IdCounterWidth = 32,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned StreamWidth    = (NumStreams > 1) ? $clog2(NumStreams) : 1,
  parameter type         dma_req_t      = logic
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  dma_req_t [NumStreams-1:0]                    stream_req_i,
  input  logic     [NumStreams-1:0]                    stream_valid_i,
  output logic     [NumStreams-1:0]                    stream_ready_o,
  output logic     [NumStreams-1:0][IdCounterWidth-1:0] next_id_o,
  output logic     [NumStreams-1:0][IdCounterWidth-1:0] done_id_o,
  output logic     [NumStreams-1:0]                    busy_o,
  output dma_req_t                                     req_o,
  output logic                                         req_valid_o,
  input  logic                                         req_ready_i,
  output logic     [StreamWidth-1:0]                   req_stream_o,
  output logic     [IdCounterWidth-1:0]                req_id_o,
  input  logic                                         done_valid_i,
  output logic                                         err_o
);

  localparam int unsigned PtrWidth = $clog2(MaxOutstanding);
  localparam int unsigned CntWidth = PtrWidth + 1;

  typedef logic [IdCounterWidth-1:0] id_t;

  // IDs wrap modulo 2^IdCounterWidth but never land on 0, which means "none completed".
  function automatic id_t id_inc(input id_t v);
    id_t n;
    n = v + id_t'(1);
    return (n == '0) ? id_t'(1) : n;
  endfunction

  logic [StreamWidth-1:0]                   last_grant;
  id_t  [NumStreams-1:0]                    next_id;
  id_t  [NumStreams-1:0]                    done_id;
  logic [NumStreams-1:0][CntWidth-1:0]      stream_cnt;
  logic [StreamWidth-1:0]                   fifo_mem [MaxOutstanding];
  logic [PtrWidth-1:0]                      wr_ptr;
  logic [PtrWidth-1:0]                      rd_ptr;
  logic [CntWidth-1:0]                      fifo_cnt;
  dma_req_t                                 req_q;
  logic                                     req_vld_q;
  logic [StreamWidth-1:0]                   req_stream_q;
  id_t                                      req_id_q;
  logic                                     err_q;

  logic                   found;
  logic [StreamWidth-1:0] grant;
  int unsigned            cand;
  logic                   can_accept;
  logic                   accept;
  logic                   pop;
  logic [StreamWidth-1:0] pop_stream;

  // Round-robin search starting one past the last granted stream.
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = 0;
    for (int unsigned i = 0; i < NumStreams; i++) begin
      cand = (int'(last_grant) + 1 + i) % NumStreams;
      if (!found && stream_valid_i[cand]) begin
        found = 1'b1;
        grant = StreamWidth'(cand);
      end
    end
  end

  // Accept gating and per-stream ready; held low while reset is asserted.
  always_comb begin
    can_accept     = rst_ni && (!req_vld_q || req_ready_i) &&
                     (fifo_cnt < CntWidth'(MaxOutstanding));
    accept         = can_accept && found;
    pop            = done_valid_i && (fifo_cnt != '0);
    pop_stream     = fifo_mem[rd_ptr];
    stream_ready_o = '0;
    if (accept) stream_ready_o[grant] = 1'b1;
  end

  // Registered output stage: loads on accept, clears when drained without a refill.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      req_q        <= '0;
      req_vld_q    <= 1'b0;
      req_stream_q <= '0;
      req_id_q     <= '0;
      last_grant   <= StreamWidth'(NumStreams - 1);
    end else if (accept) begin
      req_q        <= stream_req_i[grant];
      req_vld_q    <= 1'b1;
      req_stream_q <= grant;
      req_id_q     <= next_id[grant];
      last_grant   <= grant;
    end else if (req_ready_i) begin
      req_vld_q    <= 1'b0;
    end
  end

  // In-order tracking FIFO of issuing streams, plus the sticky spurious-completion flag.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        fifo_mem[wr_ptr] <= grant;
        wr_ptr           <= wr_ptr + PtrWidth'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PtrWidth'(1);
      if (accept && !pop)      fifo_cnt <= fifo_cnt + CntWidth'(1);
      else if (pop && !accept) fifo_cnt <= fifo_cnt - CntWidth'(1);
      if (done_valid_i && (fifo_cnt == '0)) err_q <= 1'b1;
    end
  end

  // Per-stream ID counters and outstanding counts.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int s = 0; s < NumStreams; s++) begin
        next_id[s]    <= id_t'(1);
        done_id[s]    <= '0;
        stream_cnt[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NumStreams; s++) begin
        if (accept && (grant == StreamWidth'(s))) next_id[s] <= id_inc(next_id[s]);
        if (pop && (pop_stream == StreamWidth'(s))) done_id[s] <= id_inc(done_id[s]);
        if ((accept && (grant == StreamWidth'(s))) && !(pop && (pop_stream == StreamWidth'(s))))
          stream_cnt[s] <= stream_cnt[s] + CntWidth'(1);
        else if (!(accept && (grant == StreamWidth'(s))) && (pop && (pop_stream == StreamWidth'(s))))
          stream_cnt[s] <= stream_cnt[s] - CntWidth'(1);
      end
    end
  end

  // Output wiring.
  always_comb begin
    for (int s = 0; s < NumStreams; s++) begin
      next_id_o[s] = next_id[s];
      done_id_o[s] = done_id[s];
      busy_o[s]    = (stream_cnt[s] != '0);
    end
    req_o        = req_q;
    req_valid_o  = req_vld_q;
    req_stream_o = req_stream_q;
    req_id_o     = req_id_q;
    err_o        = err_q;
  end

endmodule

// File: tb/tb_idma_stream_sched.sv
// Purpose: randomized and directed bench for idma_stream_sched with a queue-based reference model and scoreboard.
// Latency: model state advances once per cycle; outputs are sampled on the falling edge.
// Backpressure: req_ready and completion pulses are randomized per phase.
module tb_idma_stream_sched;

  localparam int NS = 4;
  localparam int IW = 4;
  localparam int MO = 8;
  typedef logic [15:0] pay_t;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  pay_t [NS-1:0]           stream_req;
  logic [NS-1:0]           stream_valid;
  logic [NS-1:0]           stream_ready;
  logic [NS-1:0][IW-1:0]   next_id;
  logic [NS-1:0][IW-1:0]   done_id;
  logic [NS-1:0]           busy;
  pay_t                    req;
  logic                    req_valid;
  logic                    req_ready;
  logic [1:0]              req_stream;
  logic [IW-1:0]           req_id;
  logic                    done_valid;
  logic                    err;

  idma_stream_sched #(
    .NumStreams(NS), .IdCounterWidth(IW), .MaxOutstanding(MO), .dma_req_t(pay_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .stream_req_i(stream_req), .stream_valid_i(stream_valid), .stream_ready_o(stream_ready),
    .next_id_o(next_id), .done_id_o(done_id), .busy_o(busy),
    .req_o(req), .req_valid_o(req_valid), .req_ready_i(req_ready),
    .req_stream_o(req_stream), .req_id_o(req_id),
    .done_valid_i(done_valid), .err_o(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: plain queues and counters following the scheduling rules.
  typedef struct { int pay; int strm; int id; } exp_t;
  exp_t sb[$];
  int   m_fifo[$];
  int   m_last;
  int   m_next[NS];
  int   m_done[NS];
  bit   m_full;
  bit   m_err;

  int  p_valid = 0, p_ready = 100, p_done = 0;
  bit  allow_spurious = 0;

  function automatic int id_inc(input int v);
    return (v == (1 << IW) - 1) ? 1 : v + 1;
  endfunction

  function automatic int owned(input int s);
    int n = 0;
    foreach (m_fifo[k]) if (m_fifo[k] == s) n++;
    return n;
  endfunction

  function automatic void model_reset();
    m_last = NS - 1;
    for (int s = 0; s < NS; s++) begin m_next[s] = 1; m_done[s] = 0; end
    m_fifo.delete();
    sb.delete();
    m_full = 0;
    m_err  = 0;
  endfunction

  // Model step: compare registered outputs, predict ready, then advance across the next edge.
  task automatic model_loop();
    forever begin
      @(negedge clk);
      for (int s = 0; s < NS; s++) begin
        check($sformatf("next_id[%0d]", s), int'(next_id[s]), m_next[s]);
        check($sformatf("done_id[%0d]", s), int'(done_id[s]), m_done[s]);
        check($sformatf("busy[%0d]", s), int'(busy[s]), (owned(s) > 0) ? 1 : 0);
      end
      check("err", int'(err), int'(m_err));
      check("req_valid", int'(req_valid), int'(m_full));
      if (!rst_n) begin
        check("ready_in_reset", int'(stream_ready), 0);
        model_reset();
      end else begin
        bit found = 0;
        int g = 0;
        bit can;
        logic [NS-1:0] exp_rdy = '0;
        can = (!m_full || req_ready) && (m_fifo.size() < MO);
        for (int i = 0; i < NS; i++) begin
          int c = (m_last + 1 + i) % NS;
          if (!found && stream_valid[c]) begin found = 1; g = c; end
        end
        if (can && found) exp_rdy[g] = 1'b1;
        check("stream_ready", int'(stream_ready), int'(exp_rdy));
        if (done_valid) begin
          if (m_fifo.size() > 0) begin
            int t = m_fifo.pop_front();
            m_done[t] = id_inc(m_done[t]);
          end else begin
            m_err = 1;
          end
        end
        if (can && found) begin
          exp_t e;
          e.pay = int'(stream_req[g]); e.strm = g; e.id = m_next[g];
          sb.push_back(e);
          m_fifo.push_back(g);
          m_next[g] = id_inc(m_next[g]);
          m_last = g;
          m_full = 1;
        end else if (req_ready) begin
          m_full = 0;
        end
      end
    end
  endtask

  // Monitor: every back-end handshake pops the oldest expected job.
  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (rst_n && req_valid && req_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_req", 1, 0);
        end else begin
          exp_t e = sb.pop_front();
          check("req_payload", int'(req), e.pay);
          check("req_stream", int'(req_stream), e.strm);
          check("req_id", int'(req_id), e.id);
        end
      end
    end
  endtask

  task automatic drive_random();
    for (int s = 0; s < NS; s++) begin
      stream_valid[s] = ($urandom_range(99) < p_valid);
      stream_req[s]   = pay_t'($urandom);
    end
    req_ready  = ($urandom_range(99) < p_ready);
    done_valid = ($urandom_range(99) < p_done) && (allow_spurious || m_fifo.size() > 0);
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      drive_random();
    end
  endtask

  task automatic one(input logic [NS-1:0] vmask, input logic rdy, input logic dn);
    @(posedge clk); #1;
    for (int s = 0; s < NS; s++) stream_req[s] = pay_t'($urandom);
    stream_valid = vmask;
    req_ready    = rdy;
    done_valid   = dn;
  endtask

  initial begin
    stream_valid = '0;
    stream_req   = '0;
    req_ready    = 1'b1;
    done_valid   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    fork
      model_loop();
      monitor_loop();
    join_none
    #1 rst_n = 1'b1;

    // Single job on stream 2, then its completion.
    one(4'b0100, 1, 0);
    one(4'b0000, 1, 0);
    one(4'b0000, 1, 0);
    one(4'b0000, 1, 1);
    one(4'b0000, 1, 0);

    // Streams 1, 3, 1 issued, then three in-order completions.
    one(4'b0010, 1, 0);
    one(4'b1000, 1, 0);
    one(4'b0010, 1, 0);
    one(4'b0000, 1, 1);
    one(4'b0000, 1, 1);
    one(4'b0000, 1, 1);
    one(4'b0000, 1, 0);

    // All streams valid, back-end always ready, no completions: fills to MaxOutstanding and stalls.
    p_valid = 100; p_ready = 100; p_done = 0;
    run(20);
    one(4'b1111, 1, 1);
    one(4'b1111, 1, 0);
    one(4'b1111, 1, 0);

    // Back-end stall with continuous requests.
    p_done = 100;
    run(6);
    p_ready = 0; p_done = 0;
    run(5);

    // Mixed random traffic; drives IDs through several wraps.
    p_valid = 60; p_ready = 70; p_done = 50;
    run(3000);

    // Spurious completions with nothing outstanding, then err must stay set.
    p_valid = 0; p_ready = 100; p_done = 100;
    run(30);
    allow_spurious = 1;
    run(10);
    allow_spurious = 0;
    p_valid = 50; p_ready = 60; p_done = 40;
    run(500);

    // Reset mid-operation, then a spurious completion afterwards.
    p_valid = 80; p_ready = 30; p_done = 0;
    run(10);
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive_random();
    @(posedge clk); #1;
    rst_n = 1'b1;
    stream_valid = '0;
    done_valid   = 1'b1;
    p_valid = 60; p_ready = 70; p_done = 50;
    run(1000);

    // Drain everything and confirm the scoreboard is empty.
    p_valid = 0; p_ready = 100; p_done = 100;
    run(40);
    @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    check("tracking_empty", int'(|busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
